seq_pattern_gen: RTL and testbench



---
 rtl/seq_pkg.sv | 12 +
 rtl/pattern_piso.sv | 27 ++
 rtl/seq_pattern_gen.sv | 140 ++++++++++++++
 tb/tb_seq_pattern_gen.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and its detector-side peers.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [3:0] DEF_PATTERN = 4'b1010;

endpackage

// File: rtl/pattern_piso.sv
// Parallel-in serial-out shift register, MSB first, zero-filled from the LSB side.
module pattern_piso #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] data,
    output logic         msb
);

    logic [W-1:0] shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= data;
        end else if (shift_en) begin
            shreg <= {shreg[W-2:0], 1'b0};
        end
    end

    assign msb = shreg[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated with optional gaps.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_SHIFT | one pattern bit on sout per cycle
// ST_GAP   | idle cycles between repetitions
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(PAT_W - 1);

    state_t             state, state_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [CNT_W-1:0]   rep_cnt, rep_cnt_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
    logic [PAT_W-1:0]   pat_q;
    logic [GAP_W-1:0]   gap_q;
    logic [PAT_W-1:0]   load_data;
    logic               load, shift_en, capture, done_nxt;

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        rep_cnt_nxt = rep_cnt;
        gap_cnt_nxt = gap_cnt;
        load        = 1'b0;
        shift_en    = 1'b0;
        load_data   = pat_q;
        capture     = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    capture     = 1'b1;
                    state_nxt   = ST_SHIFT;
                    load        = 1'b1;
                    load_data   = pattern;
                    bit_cnt_nxt = BIT_MAX;
                    rep_cnt_nxt = (repeat_n == '0) ? CNT_W'(1) : repeat_n;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    // Loading zeros guarantees sout is low from the next cycle on.
                    state_nxt   = ST_IDLE;
                    load        = 1'b1;
                    load_data   = '0;
                    bit_cnt_nxt = '0;
                    rep_cnt_nxt = '0;
                end else if (bit_cnt == '0) begin
                    rep_cnt_nxt = rep_cnt - CNT_W'(1);
                    if (rep_cnt == CNT_W'(1)) begin
                        state_nxt = ST_IDLE;
                        shift_en  = 1'b1;
                        done_nxt  = 1'b1;
                    end else if (gap_q != '0) begin
                        state_nxt   = ST_GAP;
                        shift_en    = 1'b1;
                        gap_cnt_nxt = gap_q - GAP_W'(1);
                    end else begin
                        load        = 1'b1;
                        bit_cnt_nxt = BIT_MAX;
                    end
                end else begin
                    shift_en    = 1'b1;
                    bit_cnt_nxt = bit_cnt - BIT_W'(1);
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_nxt   = ST_IDLE;
                    gap_cnt_nxt = '0;
                    rep_cnt_nxt = '0;
                end else if (gap_cnt == '0) begin
                    state_nxt   = ST_SHIFT;
                    load        = 1'b1;
                    bit_cnt_nxt = BIT_MAX;
                end else begin
                    gap_cnt_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            rep_cnt    <= '0;
            gap_cnt    <= '0;
            pat_q      <= '0;
            gap_q      <= '0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            rep_cnt    <= rep_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            if (capture) begin
                pat_q <= pattern;
                gap_q <= gap;
            end
            sout_valid <= (state_nxt == ST_SHIFT);
            busy       <= (state_nxt != ST_IDLE);
            done       <= done_nxt;
        end
    end

    // The shift register empties to zero outside SHIFT, so its MSB is sout directly.
    pattern_piso #(.W(PAT_W)) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .data     (load_data),
        .msb      (sout)
    );

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Randomized and directed bench for seq_pattern_gen against a per-cycle output queue model.
module tb_seq_pattern_gen;

    localparam int PW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort;
    logic [3:0] pattern;
    logic [7:0] repeat_n;
    logic [3:0] gap;
    logic       sout, sout_valid, busy, done;

    int n_vec = 0;
    int n_err = 0;

    // Expected future outputs, one entry per cycle: {sout_valid, sout, busy, done}
    logic [3:0] q[$];
    logic       cur_busy = 1'b0;

    logic [3:0] hist;
    int         det_cnt;

    always #5 clk = ~clk;

    seq_pattern_gen #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern    (pattern),
        .repeat_n   (repeat_n),
        .gap        (gap),
        .abort      (abort),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic build(input logic [3:0] p, input logic [7:0] r, input logic [3:0] g);
        int n;
        n = (r == 0) ? 1 : int'(r);
        q.delete();
        for (int i = 0; i < n; i++) begin
            for (int b = PW - 1; b >= 0; b--) q.push_back({1'b1, p[b], 1'b1, 1'b0});
            if (i < n - 1)
                for (int k = 0; k < int'(g); k++) q.push_back(4'b0010);
        end
        q.push_back(4'b0001);
    endtask

    task automatic cycle(input logic s, input logic a, input logic [3:0] p,
                         input logic [7:0] r, input logic [3:0] g);
        logic [3:0] e;
        start = s; abort = a; pattern = p; repeat_n = r; gap = g;
        @(posedge clk);
        if (!cur_busy) begin
            if (s && !a) build(p, r, g);
        end else if (a) begin
            q.delete();
        end
        e = (q.size() > 0) ? q.pop_front() : 4'b0000;
        cur_busy = e[1];
        #1;
        check("out", {28'd0, sout_valid, sout, busy, done}, {28'd0, e});
        if (sout_valid) begin
            hist = {hist[2:0], sout};
            if (hist == 4'b1010) det_cnt++;
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 4'($urandom), 8'($urandom), 4'($urandom));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((cur_busy || q.size() > 0) && guard < 8000) begin
            idle();
            guard++;
        end
        check("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        pattern = '0; repeat_n = '0; gap = '0;
        hist = '0; det_cnt = 0;
        #3;
        check("reset", {28'd0, sout_valid, sout, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle();

        // single transfer
        cycle(1'b1, 1'b0, 4'b1010, 8'd1, 4'd0);
        drain();

        // contiguous repeats through an overlapping 1010 detector
        hist = '0; det_cnt = 0;
        cycle(1'b1, 1'b0, 4'b1010, 8'd3, 4'd0);
        drain();
        check("det_count", det_cnt, 32'd5);

        // gap insertion, then back-to-back start in the done cycle
        cycle(1'b1, 1'b0, 4'b1100, 8'd2, 4'd3);
        while (cur_busy) idle();
        cycle(1'b1, 1'b0, 4'b0110, 8'd0, 4'd2);
        drain();

        // start and input changes while busy are ignored
        cycle(1'b1, 1'b0, 4'b1010, 8'd2, 4'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'b1111, 8'd5, 4'd2);
        drain();

        // abort on 2nd bit of rep 2 of 3, fresh start right after
        cycle(1'b1, 1'b0, 4'b1010, 8'd3, 4'd0);
        for (int i = 0; i < 5; i++) idle();
        cycle(1'b0, 1'b1, 4'b0000, 8'd0, 4'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        cycle(1'b1, 1'b0, 4'b0011, 8'd1, 4'd1);
        drain();

        // abort together with start in idle
        cycle(1'b1, 1'b1, 4'b1111, 8'd1, 4'd0);
        idle();

        // reset mid-transfer
        cycle(1'b1, 1'b0, 4'b1010, 8'd3, 4'd1);
        for (int i = 0; i < 3; i++) idle();
        #2 rst = 1'b0;
        #1 check("rst_async", {28'd0, sout_valid, sout, busy, done}, 32'd0);
        q.delete();
        cur_busy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) idle();
        cycle(1'b1, 1'b0, 4'b1001, 8'd2, 4'd1);
        drain();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0),
                  4'($urandom), 8'($urandom_range(0, 4)), 4'($urandom_range(0, 3)));
        end
        drain();

        // max-length transfer
        cycle(1'b1, 1'b0, 4'b1001, 8'd255, 4'd15);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
